// File: rtl/serial_bus_arbiter_pkg.sv
// Shared definitions for the serial bus arbiter: FSM state encoding and grant-index width.
package serial_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  localparam int NUM_MASTERS_DEFAULT = 2;

  // A one-master bus would give $clog2 == 0, so keep at least one index bit.
  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_if.sv
// Request/grant bundle between bus masters, the split-capable slave side and the arbiter.
interface serial_bus_arbiter_if
  import serial_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEFAULT
);
  localparam int ID_WIDTH = id_width(NUM_MASTERS);

  // Handshake: a master raises mreq and holds it until its transaction ends; mgrant is the
  // one-hot answer. tx_done and ssplit are single-cycle pulses that only matter while a grant
  // is live. split_ready is a level, sampled only while the bus is idle. A parked master sees
  // msplit and keeps mreq high until split_grant brings it back.
  logic [NUM_MASTERS-1:0] mreq;
  logic                   tx_done;
  logic                   ssplit;
  logic                   split_ready;
  logic [NUM_MASTERS-1:0] mgrant;
  logic [ID_WIDTH-1:0]    grant_id;
  logic [NUM_MASTERS-1:0] msplit;
  logic                   split_grant;

  modport master (
    output mreq, tx_done, ssplit, split_ready,
    input  mgrant, grant_id, msplit, split_grant
  );

  modport slave (
    input  mreq, tx_done, ssplit, split_ready,
    output mgrant, grant_id, msplit, split_grant
  );

endinterface

// File: rtl/serial_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping around.
module serial_bus_arbiter_rr_pick
  import serial_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEFAULT,
  parameter int ID_WIDTH    = id_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_WIDTH-1:0]    rr_ptr,
  output logic                   valid,
  output logic [ID_WIDTH-1:0]    index
);

  logic [ID_WIDTH-1:0] cand;

  // Walk offsets from the far end back to rr_ptr so the closest requester is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand = ID_WIDTH'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin serial bus arbiter with one outstanding split transaction (park and resume).
module serial_bus_arbiter
  import serial_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  serial_bus_arbiter_if.slave  bus,
  output state_t               dbg_state
);

  localparam int ID_WIDTH = id_width(NUM_MASTERS);
  typedef logic [ID_WIDTH-1:0] id_t;

  state_t                 state;
  logic [NUM_MASTERS-1:0] mgrant;
  logic [NUM_MASTERS-1:0] msplit;
  id_t                    grant_id;
  id_t                    rr_ptr;
  id_t                    split_owner;
  logic                   split_grant;
  logic                   split_pending;

  logic [NUM_MASTERS-1:0] eligible;
  logic                   pick_valid;
  id_t                    pick_idx;
  id_t                    next_ptr;
  logic                   owner_done;

  function automatic logic [NUM_MASTERS-1:0] onehot(id_t i);
    logic [NUM_MASTERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // A parked master keeps mreq high, so msplit masks it out of normal selection.
  assign eligible   = bus.mreq & ~msplit;
  assign next_ptr   = (grant_id == id_t'(NUM_MASTERS - 1)) ? '0 : grant_id + 1'b1;
  assign owner_done = bus.tx_done | ~bus.mreq[grant_id];

  serial_bus_arbiter_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .ID_WIDTH    (ID_WIDTH)
  ) u_rr_pick (
    .req    (eligible),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      mgrant        <= '0;
      grant_id      <= '0;
      msplit        <= '0;
      split_grant   <= 1'b0;
      rr_ptr        <= '0;
      split_pending <= 1'b0;
      split_owner   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Resuming the parked transaction beats any fresh request.
          if (split_pending && bus.split_ready) begin
            state       <= ST_RESUME;
            mgrant      <= onehot(split_owner);
            grant_id    <= split_owner;
            split_grant <= 1'b1;
            msplit      <= '0;
          end else if (pick_valid) begin
            state    <= ST_BUSY;
            mgrant   <= onehot(pick_idx);
            grant_id <= pick_idx;
          end
        end
        ST_BUSY: begin
          // A split wins over a simultaneous tx_done; a second split is dropped.
          if (bus.ssplit && !split_pending) begin
            split_pending    <= 1'b1;
            split_owner      <= grant_id;
            msplit[grant_id] <= 1'b1;
            mgrant           <= '0;
            rr_ptr           <= next_ptr;
            state            <= ST_IDLE;
          end else if (owner_done) begin
            mgrant <= '0;
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        ST_RESUME: begin
          if (owner_done) begin
            split_pending <= 1'b0;
            split_grant   <= 1'b0;
            mgrant        <= '0;
            rr_ptr        <= next_ptr;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mgrant      = mgrant;
  assign bus.grant_id    = grant_id;
  assign bus.msplit      = msplit;
  assign bus.split_grant = split_grant;
  assign dbg_state       = state;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed plus randomized check of serial_bus_arbiter against an owner/parked-slot reference model.
module tb_serial_bus_arbiter;
  import serial_bus_arbiter_pkg::*;

  localparam int N   = 2;
  localparam int IDW = 1;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rstn;
  state_t dbg_state;

  always #5 clk = ~clk;

  serial_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  serial_bus_arbiter #(.NUM_MASTERS(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // The bus is either free (owner < 0) or held by one master; a single parking slot
  // remembers a split master until it is resumed.
  int n_assert = 0;
  int n_fail   = 0;
  int m_owner  = -1;
  int m_parked = -1;
  int m_ptr    = 0;
  int m_gid    = 0;
  bit m_resume = 1'b0;

  function automatic bit bit_at(logic [N-1:0] v, int k);
    return |(v & (N'(1) << k));
  endfunction

  task automatic model_step();
    logic [N-1:0] r;
    r = bus.mreq;
    if (!rstn) begin
      m_owner = -1; m_parked = -1; m_ptr = 0; m_gid = 0; m_resume = 1'b0;
    end else if (m_owner < 0) begin
      if (m_parked >= 0 && bus.split_ready) begin
        m_owner = m_parked; m_gid = m_parked; m_resume = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (bit_at(r, c) && c != m_parked) begin
            m_owner = c; m_gid = c;
            break;
          end
        end
      end
    end else if (m_resume) begin
      if (bus.tx_done || !bit_at(r, m_owner)) begin
        m_parked = -1; m_resume = 1'b0; m_ptr = (m_owner + 1) % N; m_owner = -1;
      end
    end else if (bus.ssplit && m_parked < 0) begin
      m_parked = m_owner; m_ptr = (m_owner + 1) % N; m_owner = -1;
    end else if (bus.tx_done || !bit_at(r, m_owner)) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] e_grant, e_split;
    state_t       e_state;
    e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_split = (m_parked >= 0 && !m_resume) ? (N'(1) << m_parked) : '0;
    e_state = (m_owner < 0) ? ST_IDLE : (m_resume ? ST_RESUME : ST_BUSY);
    chk("model_mgrant",      32'(bus.mgrant),      32'(e_grant));
    chk("model_grant_id",    32'(bus.grant_id),    32'(m_gid));
    chk("model_msplit",      32'(bus.msplit),      32'(e_split));
    chk("model_split_grant", 32'(bus.split_grant), 32'(m_resume));
    chk("model_state",       32'(dbg_state),       32'(e_state));
    chk("mgrant_onehot0",    32'($onehot0(bus.mgrant)), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    bus.mreq = '0; bus.tx_done = 1'b0; bus.ssplit = 1'b0; bus.split_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    tick();
    chk("rst_mgrant",      32'(bus.mgrant),      32'd0);
    chk("rst_grant_id",    32'(bus.grant_id),    32'd0);
    chk("rst_msplit",      32'(bus.msplit),      32'd0);
    chk("rst_split_grant", 32'(bus.split_grant), 32'd0);
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] nm;
    rstn = 1'b0;
    idle_inputs();
    tick();
    do_reset();

    // 1: single request, grant next cycle, release the cycle after tx_done
    bus.mreq = 2'b01;
    tick();
    chk("t1_grant", 32'(bus.mgrant), 32'h1);
    chk("t1_gid",   32'(bus.grant_id), 32'd0);
    repeat (3) tick();
    chk("t1_hold", 32'(bus.mgrant), 32'h1);
    bus.tx_done = 1'b1;
    tick();
    chk("t1_release", 32'(bus.mgrant), 32'h0);
    bus.tx_done = 1'b0; bus.mreq = '0;
    tick();

    // 2: contention, alternating grants with an idle bubble between them
    do_reset();
    bus.mreq = 2'b11;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("t2_grant", 32'(bus.mgrant), 32'(N'(1) << (g % 2)));
      repeat (2) tick();
      bus.tx_done = 1'b1;
      tick();
      chk("t2_gap", 32'(bus.mgrant), 32'h0);
      bus.tx_done = 1'b0;
    end
    bus.mreq = '0;
    tick();

    // 3: split, other master served, split_ready ignored while busy, then resume
    do_reset();
    bus.mreq = 2'b11;
    tick();
    chk("t3_grant_m0", 32'(bus.mgrant), 32'h1);
    tick();
    bus.ssplit = 1'b1;
    tick();
    chk("t3_split_free", 32'(bus.mgrant), 32'h0);
    chk("t3_msplit",     32'(bus.msplit), 32'h1);
    bus.ssplit = 1'b0;
    tick();
    chk("t3_grant_m1", 32'(bus.mgrant), 32'h2);
    bus.split_ready = 1'b1;
    tick();
    chk("t3_busy_hold", 32'(bus.mgrant), 32'h2);
    bus.tx_done = 1'b1;
    tick();
    chk("t3_m1_release", 32'(bus.mgrant), 32'h0);
    bus.tx_done = 1'b0;
    tick();
    chk("t3_resume_grant", 32'(bus.mgrant),      32'h1);
    chk("t3_resume_sg",    32'(bus.split_grant), 32'd1);
    chk("t3_resume_msplit",32'(bus.msplit),      32'h0);
    tick();
    bus.tx_done = 1'b1;
    tick();
    chk("t3_end_grant", 32'(bus.mgrant),      32'h0);
    chk("t3_end_sg",    32'(bus.split_grant), 32'd0);
    idle_inputs();
    tick();

    // 4: ssplit together with tx_done takes the split path; parked request is masked
    do_reset();
    bus.mreq = 2'b01;
    tick();
    bus.ssplit = 1'b1; bus.tx_done = 1'b1;
    tick();
    chk("t4_msplit", 32'(bus.msplit), 32'h1);
    chk("t4_free",   32'(bus.mgrant), 32'h0);
    bus.ssplit = 1'b0; bus.tx_done = 1'b0;
    tick();
    chk("t4_masked", 32'(bus.mgrant), 32'h0);

    // 5: owner abort advances the round-robin pointer
    do_reset();
    bus.mreq = 2'b11;
    tick();
    tick();
    bus.mreq = 2'b10;
    tick();
    chk("t5_abort", 32'(bus.mgrant), 32'h0);
    bus.mreq = 2'b11;
    tick();
    chk("t5_next_m1", 32'(bus.mgrant), 32'h2);
    idle_inputs();
    tick();

    // 6: reset during RESUME forgets the pending split
    do_reset();
    bus.mreq = 2'b10;
    tick();
    bus.ssplit = 1'b1;
    tick();
    bus.ssplit = 1'b0; bus.split_ready = 1'b1;
    tick();
    chk("t6_resume_sg",  32'(bus.split_grant), 32'd1);
    chk("t6_resume_gid", 32'(bus.grant_id),    32'd1);
    rstn = 1'b0;
    tick();
    chk("t6_rst_grant",  32'(bus.mgrant),      32'h0);
    chk("t6_rst_msplit", 32'(bus.msplit),      32'h0);
    chk("t6_rst_sg",     32'(bus.split_grant), 32'd0);
    chk("t6_rst_gid",    32'(bus.grant_id),    32'd0);
    rstn = 1'b1;
    tick();
    chk("t6_plain_grant", 32'(bus.mgrant),      32'h2);
    chk("t6_plain_sg",    32'(bus.split_grant), 32'd0);
    idle_inputs();
    tick();

    // randomized traffic against the model; only one split may be outstanding
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nm = bus.mreq;
      for (int k = 0; k < N; k++) begin
        if (k == m_owner || k == m_parked) begin
          if ($urandom_range(0, 39) == 0) nm = nm ^ (N'(1) << k);
        end else if ($urandom_range(0, 5) == 0) begin
          nm = nm ^ (N'(1) << k);
        end
      end
      bus.mreq        = nm;
      bus.tx_done     = (m_owner >= 0) && ($urandom_range(0, 3) == 0);
      bus.ssplit      = (m_owner >= 0) && (m_resume || m_parked < 0) && ($urandom_range(0, 5) == 0);
      bus.split_ready = ($urandom_range(0, 2) == 0);
      rstn            = ($urandom_range(0, 499) != 0);
      tick();
    end
    rstn = 1'b1;
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
